apb_completer: RTL
==================

// Module: apb_completer
// PURPOSE
//  APB completer (slave) at the far end of the team's APB initiator. It holds an
//  8-bit register file addressed by paddr and answers single read/write transfers.
//  The initiator-to-completer handshake is psel/penable in, pready/pslverr out.
//  A wait-state counter sets the response latency.
//  Address/data widths match the initiator: 5-bit paddr, 8-bit pwdata/prdata.
// PARAMETERS
//  ADDR_W       5    paddr width
//  DATA_W       8    pwdata/prdata width
//  MEM_DEPTH    24   implemented locations 0..MEM_DEPTH-1 (<= 2**ADDR_W); higher addresses are errors
//  WAIT_STATES  0    ACCESS cycles with pready=0 before completion (0..15)
// PORTS
//  pclk       in   1       clock; all logic on posedge
//  preset     in   1       synchronous, active-high reset
//  psel       in   1       completer selected
//  penable    in   1       access phase
//  pwrite     in   1       1=write, 0=read
//  paddr      in   ADDR_W  transfer address
//  pwdata     in   DATA_W  write data
//  prdata     out  DATA_W  read data; valid only while pready=1 on a read
//  pready     out  1       transfer completes this cycle
//  pslverr    out  1       error response; valid only while pready=1
//  proto_err  out  1       sticky; set on an APB protocol violation; cleared only by preset
// BEHAVIOUR
//  - Reset: one clock with preset=1.
//    - prdata=0, pready=0, pslverr=0, proto_err=0.
//    - All MEM_DEPTH locations cleared to 0.
//    - FSM goes to IDLE and wait counter to 0.
//  - Reset mid-transfer aborts the transfer; no memory write occurs.
//  - FSM states: IDLE, ACCESS.
//  - IDLE, psel=1 & penable=0 (setup cycle):
//    - At the edge, latch pwrite, paddr and pwdata; load cnt=WAIT_STATES; go to ACCESS.
//    - If WAIT_STATES=0, register pready=1 at the same edge.
//    - If WAIT_STATES=0 on a read, also register prdata=mem[paddr].
//    - If WAIT_STATES=0 and paddr>=MEM_DEPTH, also register pslverr=1 (prdata stays 0).
//    - Result: zero-wait transfers finish in the first access cycle (2 cycles total).
//  - IDLE, psel=1 & penable=1 (access with no setup): set proto_err; no response.
//  - ACCESS, psel=1 & penable=1 & pready=0:
//    - Decrement cnt.
//    - When cnt goes 1->0, register pready=1, with prdata/pslverr as above.
//    - Total transfer = 2+WAIT_STATES cycles.
//  - ACCESS, psel=1 & penable=1 & pready=1 (completion edge):
//    - Write with pslverr=0: mem[latched addr] <= latched pwdata.
//    - Clear pready, pslverr and prdata to 0; go to IDLE.
//    - A new setup on the next cycle is accepted normally (back-to-back transfers).
//  - ACCESS, psel=0 (initiator abort): set proto_err; go to IDLE.
//    - No write; pready/pslverr/prdata cleared.
//  - ACCESS, psel=1 & penable=0: counts as a new setup. Set proto_err, drop the old
//    transfer without writing, relatch and restart cnt.
//  - Changes on paddr/pwrite/pwdata during ACCESS are ignored; latched values are used.
//  - Errored writes never modify memory. Errored reads return prdata=0.
//  - pready is never high outside ACCESS. prdata is 0 whenever pready=0.
// STRUCTURE
//  - Shared package apb_pkg:
//    - Constants APB_ADDR_W=5 and APB_DATA_W=8.
//    - State typedef apb_cpl_state_t {IDLE, ACCESS}.
//  - Sub-module apb_regfile: MEM_DEPTH x DATA_W storage.
//    - Synchronous write port (we, waddr, wdata).
//    - Combinational read port.
//    - Synchronous clear on preset.
//  - Top level holds the FSM, wait counter, latches, error decode and output registers.
// TESTING
//  1. Reset with WAIT_STATES=0 and MEM_DEPTH=24 -> all outputs 0. Then read every
//     address 0..23 -> prdata=0x00, pslverr=0.
//  2. Write 0xA5 to addr 3, then read addr 3, back to back, WAIT_STATES=0 ->
//     - pready high in the 2nd cycle of each transfer.
//     - The read returns 0xA5.
//  3. WAIT_STATES=3: read addr 3 -> pready low for 3 access cycles, high on the 4th.
//     Transfer takes 5 cycles; prdata=0xA5.
//  4. Write 0x3C to addr 28 -> pready=1 with pslverr=1.
//     Read addr 28 -> pslverr=1, prdata=0x00.
//     Locations 0..23 unchanged.
//  5. psel deasserted mid-ACCESS of a write (WAIT_STATES=2) -> proto_err=1, no write.
//     preset pulse clears proto_err. penable=1 with no setup -> proto_err=1.
//  6. preset asserted during the ACCESS phase of a write of 0x77 to addr 5 ->
//     - pready stays 0.
//     - A later read of addr 5 returns 0x00.

Source files
------------

// File: rtl/apb_pkg.sv
// Constants and types shared by the APB initiator and completer.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 5;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_cpl_state_t;

endpackage

// File: rtl/apb_regfile.sv
// Register storage for the APB completer: synchronous write and clear, combinational read.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W    = APB_ADDR_W,
  parameter int unsigned DATA_W    = APB_DATA_W,
  parameter int unsigned MEM_DEPTH = 24
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (32'(waddr) < MEM_DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Unimplemented locations read as zero.
  assign rdata = (32'(raddr) < MEM_DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/apb_completer.sv
// APB completer: register file behind a psel/penable handshake with programmable wait states.
module apb_completer
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned MEM_DEPTH   = 24,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              proto_err
);

  apb_cpl_state_t state_q, state_d;

  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              proto_err_q, proto_err_d;

  logic              setup;
  logic              complete;
  logic              cpl_write;
  logic              cpl_err;
  logic [ADDR_W-1:0] cpl_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign setup = psel & ~penable;

  apb_regfile #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_regfile (
    .pclk  (pclk),
    .preset(preset),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (cpl_addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup) state_d = ACCESS;
      ACCESS:  if (!psel || (penable && pready_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A setup cycle is taken in either state; in ACCESS it also flags a protocol error.
  always_comb begin
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    complete    = 1'b0;
    cpl_addr    = addr_q;
    cpl_write   = write_q;

    if (setup) begin
      write_d   = pwrite;
      addr_d    = paddr;
      wdata_d   = pwdata;
      cnt_d     = 4'(WAIT_STATES);
      cpl_addr  = paddr;
      cpl_write = pwrite;
      complete  = (WAIT_STATES == 0);
      if (state_q == ACCESS) proto_err_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (psel) proto_err_d = 1'b1;
    end else if (!psel) begin
      proto_err_d = 1'b1;
    end else if (pready_q) begin
      mem_we = write_q & ~pslverr_q;
    end else begin
      cnt_d    = cnt_q - 4'd1;
      complete = (cnt_q == 4'd1);
    end

    cpl_err   = !(32'(cpl_addr) < MEM_DEPTH);
    pready_d  = complete;
    pslverr_d = complete & cpl_err;
    prdata_d  = (complete && !cpl_write && !cpl_err) ? mem_rdata : '0;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign proto_err = proto_err_q;

endmodule
